fpu_issue_ctl: RTL and testbench

FPU_ISSUE_CTL -- requirements
Module: fpu_issue_ctl

---
 rtl/swerv_types.sv | 23 ++
 rtl/fpu_rr_arb2.sv | 15 +
 rtl/fpu_issue_ctl.sv | 121 ++++++++++++
 tb/tb_fpu_issue_ctl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swerv_types.sv
// Shared SweRV type definitions used by the FPU issue path.
// Holds the op descriptor, the issue-control FSM states and the latency preload helper.
package swerv_types;

    typedef struct packed {
        logic       valid;
        logic       fma;
        logic [4:0] op;
        logic [2:0] rm;
    } fpu_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } fpu_ctl_state_t;

    // The grant cycle and the WB entry cycle are not counted, hence the -2 preload.
    function automatic logic [2:0] fpu_lat_cnt(input logic fma, input int lat_base, input int lat_fma);
        return fma ? 3'(lat_fma - 2) : 3'(lat_base - 2);
    endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter: ptr=0 favours req[0], ptr=1 favours req[1].
// The grant is onehot-or-zero and purely combinational.
module fpu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~ptr);
        gnt[1] = req[1] & (~req[0] |  ptr);
    end

endmodule

// File: rtl/fpu_issue_ctl.sv
// FPU issue controller: arbitrates the two pipes, issues one op at a time,
// counts the op latency and holds the writeback until it is accepted or flushed.
module fpu_issue_ctl
    import swerv_types::*;
#(
    parameter int LAT_BASE = 3,
    parameter int LAT_FMA  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i0_req,
    input  logic       i1_req,
    input  fpu_pkt_t   i0_pkt,
    input  fpu_pkt_t   i1_pkt,
    input  logic [4:0] i0_rd,
    input  logic [4:0] i1_rd,
    output logic       i0_gnt,
    output logic       i1_gnt,
    input  logic       flush,
    output logic       fpu_valid,
    output fpu_pkt_t   fpu_pkt,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_src,
    input  logic       wb_ready,
    output logic       busy
);

    fpu_ctl_state_t state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           ptr_q, ptr_d;
    logic           fpu_valid_q, fpu_valid_d;
    fpu_pkt_t       pkt_q, pkt_d;
    logic [4:0]     rd_q, rd_d;
    logic           src_q, src_d;

    logic [1:0]     arb_req;
    logic [1:0]     arb_gnt;
    fpu_pkt_t       sel_pkt;

    // Requests only reach the arbiter while idle and not flushing.
    assign arb_req = (state_q == IDLE && !flush) ? {i1_req, i0_req} : 2'b00;

    fpu_rr_arb2 u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    assign sel_pkt = arb_gnt[1] ? i1_pkt : i0_pkt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        fpu_valid_d = 1'b0;
        pkt_d       = pkt_q;
        rd_d        = rd_q;
        src_d       = src_q;

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d     = EXEC;
                    src_d       = arb_gnt[1];
                    pkt_d       = sel_pkt;
                    rd_d        = arb_gnt[1] ? i1_rd : i0_rd;
                    cnt_d       = fpu_lat_cnt(sel_pkt.fma, LAT_BASE, LAT_FMA);
                    fpu_valid_d = 1'b1;
                    ptr_d       = arb_gnt[0];
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WB: begin
                if (flush || wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            ptr_q       <= 1'b0;
            fpu_valid_q <= 1'b0;
            pkt_q       <= '0;
            rd_q        <= 5'd0;
            src_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            fpu_valid_q <= fpu_valid_d;
            pkt_q       <= pkt_d;
            rd_q        <= rd_d;
            src_q       <= src_d;
        end
    end

    // A flush in WB cancels the writeback in the same cycle.
    assign wb_valid  = (state_q == WB) && !flush;
    assign i0_gnt    = arb_gnt[0];
    assign i1_gnt    = arb_gnt[1];
    assign fpu_valid = fpu_valid_q;
    assign fpu_pkt   = pkt_q;
    assign wb_rd     = rd_q;
    assign wb_src    = src_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// Self-checking bench for fpu_issue_ctl: table-driven single ops with a writeback
// scoreboard, plus hand-written contention, flush and reset sequences.
`timescale 1ns/1ps
module tb_fpu_issue_ctl;
    import swerv_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i0_req, i1_req;
    fpu_pkt_t   i0_pkt, i1_pkt;
    logic [4:0] i0_rd, i1_rd;
    logic       i0_gnt, i1_gnt;
    logic       flush;
    logic       fpu_valid;
    fpu_pkt_t   fpu_pkt;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_src;
    logic       wb_ready;
    logic       busy;

    always #5 clk = ~clk;

    fpu_issue_ctl #(.LAT_BASE(3), .LAT_FMA(5)) dut (
        .clk(clk), .rst(rst),
        .i0_req(i0_req), .i1_req(i1_req),
        .i0_pkt(i0_pkt), .i1_pkt(i1_pkt),
        .i0_rd(i0_rd), .i1_rd(i1_rd),
        .i0_gnt(i0_gnt), .i1_gnt(i1_gnt),
        .flush(flush),
        .fpu_valid(fpu_valid), .fpu_pkt(fpu_pkt),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_src(wb_src),
        .wb_ready(wb_ready), .busy(busy)
    );

    typedef struct {
        logic       req0, req1;
        fpu_pkt_t   pkt0, pkt1;
        logic [4:0] rd0, rd1;
        int         bp;
        logic       exp_src;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       src;
        int         lat;
        fpu_pkt_t   pkt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic rr_q[$];
    vec_t vecs[7];

    function automatic fpu_pkt_t mk_pkt(input logic v, input logic fma, input logic [4:0] op, input logic [2:0] rm);
        fpu_pkt_t p;
        p.valid = v;
        p.fma   = fma;
        p.op    = op;
        p.rm    = rm;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic doReset();
        rst = 1'b1; i0_req = 1'b0; i1_req = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        settle();
        while (busy && n < 30) begin
            step();
            settle();
            n++;
        end
        checkOutput("idle_reached", busy, 0);
        step();
    endtask

    // One op from grant to retirement; expectations come from the vector, not the DUT.
    task automatic applyStimulus(input vec_t v);
        exp_t e, got;
        int   k;
        bit   seen;
        e.src = v.exp_src;
        e.rd  = v.exp_src ? v.rd1 : v.rd0;
        e.pkt = v.exp_src ? v.pkt1 : v.pkt0;
        e.lat = v.exp_lat;
        i0_req = v.req0; i1_req = v.req1;
        i0_pkt = v.pkt0; i1_pkt = v.pkt1;
        i0_rd  = v.rd0;  i1_rd  = v.rd1;
        wb_ready = (v.bp == 0);
        settle();
        checkOutput("gnt_i0", i0_gnt, !v.exp_src);
        checkOutput("gnt_i1", i1_gnt, v.exp_src);
        sb.push_back(e);
        step();
        i0_req = 1'b0; i1_req = 1'b0;
        settle();
        checkOutput("fpu_valid_t1", fpu_valid, 1);
        checkOutput("fpu_pkt_t1", 32'(fpu_pkt), 32'(e.pkt));
        checkOutput("wb_early", wb_valid, 0);
        k = 1;
        seen = 0;
        while (!seen && k < 20) begin
            step();
            k++;
            settle();
            checkOutput("fpu_valid_pulse", fpu_valid, 0);
            if (wb_valid) seen = 1;
        end
        got = sb.pop_front();
        if (!seen) begin
            checkOutput("wb_timeout", 0, 1);
        end else begin
            checkOutput("wb_latency", k, got.lat);
            checkOutput("wb_rd", wb_rd, got.rd);
            checkOutput("wb_src", wb_src, got.src);
            checkOutput("fpu_pkt_held", 32'(fpu_pkt), 32'(got.pkt));
            if (v.bp > 0) begin
                for (int j = 1; j < v.bp; j++) begin
                    step();
                    settle();
                    checkOutput("bp_wb_valid", wb_valid, 1);
                    checkOutput("bp_wb_rd", wb_rd, got.rd);
                    checkOutput("bp_wb_src", wb_src, got.src);
                end
                step();
                wb_ready = 1'b1;
                settle();
                checkOutput("bp_release_valid", wb_valid, 1);
            end
        end
        step();
        settle();
        checkOutput("retire_busy", busy, 0);
        checkOutput("retire_wb_valid", wb_valid, 0);
        step();
    endtask

    initial begin
        int k;
        i0_pkt = '0; i1_pkt = '0; i0_rd = 5'd0; i1_rd = 5'd0;

        vecs[0] = '{1, 0, mk_pkt(1, 0, 5'd1, 3'd0), mk_pkt(0, 0, 5'd0, 3'd0), 5'd7,  5'd0,  0, 0, 3};
        vecs[1] = '{0, 1, mk_pkt(0, 0, 5'd0, 3'd0), mk_pkt(1, 1, 5'd2, 3'd1), 5'd0,  5'd12, 0, 1, 5};
        vecs[2] = '{1, 1, mk_pkt(1, 1, 5'd3, 3'd2), mk_pkt(1, 0, 5'd4, 3'd3), 5'd3,  5'd4,  0, 0, 5};
        vecs[3] = '{1, 1, mk_pkt(1, 0, 5'd5, 3'd4), mk_pkt(0, 1, 5'd6, 3'd5), 5'd5,  5'd6,  0, 1, 5};
        vecs[4] = '{0, 1, mk_pkt(0, 0, 5'd0, 3'd0), mk_pkt(0, 0, 5'd9, 3'd6), 5'd0,  5'd9,  4, 1, 3};
        vecs[5] = '{1, 0, mk_pkt(0, 1, 5'd31, 3'd7), mk_pkt(0, 0, 5'd0, 3'd0), 5'd31, 5'd0, 0, 0, 5};
        vecs[6] = '{1, 1, mk_pkt(1, 0, 5'd10, 3'd1), mk_pkt(1, 0, 5'd11, 3'd2), 5'd1, 5'd2, 0, 1, 3};

        doReset();
        settle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_fpu_valid", fpu_valid, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_fpu_pkt", 32'(fpu_pkt), 0);
        checkOutput("rst_wb_rd", wb_rd, 0);
        checkOutput("rst_wb_src", wb_src, 0);
        step();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Contention: both requesters held, grants must alternate starting at i0.
        doReset();
        i0_req = 1'b1; i1_req = 1'b1;
        i0_pkt = mk_pkt(1, 0, 5'd1, 3'd0); i1_pkt = mk_pkt(1, 0, 5'd2, 3'd0);
        i0_rd = 5'd10; i1_rd = 5'd20;
        rr_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 40 && rr_q.size() > 0; c++) begin
            settle();
            checkOutput("gnt_onehot", {31'd0, i0_gnt & i1_gnt}, 0);
            if (i0_gnt | i1_gnt) checkOutput("rr_order", i1_gnt, rr_q.pop_front());
            step();
        end
        checkOutput("rr_grants_left", rr_q.size(), 0);
        i0_req = 1'b0; i1_req = 1'b0;
        waitIdle();

        // Flush two cycles into an FMA op; the waiting i0 request wins right after.
        doReset();
        i1_req = 1'b1; i1_pkt = mk_pkt(1, 1, 5'd3, 3'd0); i1_rd = 5'd12;
        settle();
        checkOutput("fl_gnt_i1", i1_gnt, 1);
        step();
        i1_req = 1'b0; i0_req = 1'b1; i0_pkt = mk_pkt(1, 0, 5'd4, 3'd0); i0_rd = 5'd8;
        settle();
        checkOutput("fl_gnt_busy", i0_gnt, 0);
        step();
        flush = 1'b1;
        settle();
        checkOutput("fl_busy_t2", busy, 1);
        checkOutput("fl_gnt_flush", i0_gnt, 0);
        step();
        flush = 1'b0;
        settle();
        checkOutput("fl_idle_t3", busy, 0);
        checkOutput("fl_pending_gnt", i0_gnt, 1);
        checkOutput("fl_wb_t3", wb_valid, 0);
        step();
        i0_req = 1'b0;
        k = 1;
        settle();
        while (!wb_valid && k < 15) begin
            step();
            settle();
            k++;
        end
        checkOutput("fl_next_lat", k, 3);
        checkOutput("fl_next_src", wb_src, 0);
        checkOutput("fl_next_rd", wb_rd, 8);
        step();
        waitIdle();

        // Flush together with wb_ready in WB cancels the writeback.
        i0_req = 1'b1; i0_pkt = mk_pkt(1, 0, 5'd5, 3'd0); i0_rd = 5'd15; wb_ready = 1'b0;
        settle();
        checkOutput("fw_gnt", i0_gnt, 1);
        step();
        i0_req = 1'b0;
        k = 0;
        settle();
        while (!wb_valid && k < 15) begin
            step();
            settle();
            k++;
        end
        checkOutput("fw_reached_wb", wb_valid, 1);
        step();
        flush = 1'b1; wb_ready = 1'b1;
        settle();
        checkOutput("fw_wb_suppressed", wb_valid, 0);
        step();
        flush = 1'b0;
        settle();
        checkOutput("fw_idle", busy, 0);
        checkOutput("fw_no_wb", wb_valid, 0);
        step();

        // Reset during EXEC after an i0 grant (pointer at i1) must restore pointer to i0.
        doReset();
        i0_req = 1'b1; i0_pkt = mk_pkt(1, 1, 5'd6, 3'd3); i0_rd = 5'd7;
        settle();
        checkOutput("rx_gnt_i0", i0_gnt, 1);
        step();
        i0_req = 1'b0; rst = 1'b1;
        settle();
        checkOutput("rx_exec_strobe", fpu_valid, 1);
        step();
        rst = 1'b0; i0_req = 1'b1; i1_req = 1'b1;
        settle();
        checkOutput("rx_busy", busy, 0);
        checkOutput("rx_fpu_valid", fpu_valid, 0);
        checkOutput("rx_wb_valid", wb_valid, 0);
        checkOutput("rx_fpu_pkt", 32'(fpu_pkt), 0);
        checkOutput("rx_wb_rd", wb_rd, 0);
        checkOutput("rx_wb_src", wb_src, 0);
        checkOutput("rx_first_i0", i0_gnt, 1);
        checkOutput("rx_first_not_i1", i1_gnt, 0);
        step();
        i0_req = 1'b0; i1_req = 1'b0;
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
